// File: rtl/ifte_operand_stage.sv
// Two-entry skid-buffered valid/ready stage feeding the 8-bit if-then-else mux.
// Optional `par` output (stored even parity of {i,t,e}) when IFTE_OPERAND_STAGE_PARITY_EN is defined.
module ifte_operand_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_then,
    input  logic [WIDTH-1:0] in_else,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic             i,
    output logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] e,
    output logic             out_vld,
    input  logic             out_rdy
`ifdef IFTE_OPERAND_STAGE_PARITY_EN
    ,
    output logic             par
`endif
);

    typedef struct packed {
        logic             sel;
        logic [WIDTH-1:0] thn;
        logic [WIDTH-1:0] els;
`ifdef IFTE_OPERAND_STAGE_PARITY_EN
        logic             par;
`endif
    } tuple_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    tuple_t main_q, skid_q, in_tuple;
    logic   load_main_in, load_main_skid, load_skid_in;

    always_comb begin
        in_tuple     = '0;
        in_tuple.sel = in_sel;
        in_tuple.thn = in_then;
        in_tuple.els = in_else;
`ifdef IFTE_OPERAND_STAGE_PARITY_EN
        // parity is fixed at write time and travels with the entry
        in_tuple.par = ^{in_sel, in_then, in_else};
`endif
    end

    // Handshake flags come from the registered state alone, so out_rdy never reaches in_rdy.
    assign in_rdy  = (state_q != FULL);
    assign out_vld = (state_q == ONE) || (state_q == FULL);

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_vld) begin
                    load_main_in = 1'b1;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (in_vld && out_rdy) begin
                    load_main_in = 1'b1;
                end else if (in_vld) begin
                    load_skid_in = 1'b1;
                    state_d      = FULL;
                end else if (out_rdy) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_rdy) begin
                    load_main_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in)
                main_q <= in_tuple;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid_in)
                skid_q <= in_tuple;
        end
    end

    // main register drives the mux directly; values persist through EMPTY
    assign i = main_q.sel;
    assign t = main_q.thn;
    assign e = main_q.els;
`ifdef IFTE_OPERAND_STAGE_PARITY_EN
    assign par = main_q.par;
`endif

endmodule
